// File: rtl/if_fetch_redirect_if.sv
// Instruction-memory read handshake between the IF fetch unit and the memory.
// master: fetch unit (issues reads), slave: instruction memory (responds).
interface if_fetch_redirect_if;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_redirect.sv
// IF-stage fetch and PC unit for the LC-3b pipeline.
// Owns the PC, issues instruction-memory reads (at most one outstanding),
// presents fetched words to IF/ID through a one-entry output register backed
// by a one-entry skid buffer, and redirects fetch on a taken EX branch.
// A redirect that lands while a read is outstanding is parked in pend_pc_r;
// the read is allowed to finish at its original address and its data dropped.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_redirects/perf_squashed.
module if_fetch_redirect #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_enable,
  input  logic [15:0]          br_addr,
  input  logic                 stall,
  if_fetch_redirect_if.master  imem,
  output logic                 if_valid,
  output logic [15:0]          if_pc,
  output logic [15:0]          if_pc_plus2,
  output logic [15:0]          if_ir,
  output logic                 flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_redirects,
  output logic [31:0]          perf_squashed
`endif
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_n;
  logic [15:0] pc_r;
  logic [15:0] pc_n;
  logic [15:0] pend_pc_r;
  logic [15:0] pend_pc_n;
  logic [15:0] pc_plus2_s;

  logic        if_valid_r;
  logic [15:0] if_pc_r;
  logic [15:0] if_pc_plus2_r;
  logic [15:0] if_ir_r;

  logic        skid_valid_r;
  logic [15:0] skid_pc_r;
  logic [15:0] skid_ir_r;

  logic        can_load_s;
  logic        consume_s;
  logic        out_load_mem_s;
  logic        out_load_skid_s;
  logic        skid_load_s;
  logic        drop_resp_s;

  assign pc_plus2_s = pc_r + 16'd2;
  // Output register may take a new word when it is empty or drained this edge.
  assign can_load_s = !if_valid_r || !stall;
  assign consume_s  = if_valid_r && !stall;

  assign if_valid    = if_valid_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus2 = if_pc_plus2_r;
  assign if_ir       = if_ir_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, next-PC and datapath load decisions.
  always_comb begin
    state_n         = state_r;
    pc_n            = pc_r;
    pend_pc_n       = pend_pc_r;
    out_load_mem_s  = 1'b0;
    out_load_skid_s = 1'b0;
    skid_load_s     = 1'b0;
    drop_resp_s     = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (imem.imem_resp && branch_enable) begin
          // Redirect beats a same-cycle response; the word is dropped.
          drop_resp_s = 1'b1;
          pc_n        = br_addr;
          state_n     = ST_REQ;
        end else if (imem.imem_resp) begin
          pc_n = pc_plus2_s;
          if (can_load_s) begin
            out_load_mem_s = 1'b1;
            state_n        = ST_REQ;
          end else begin
            skid_load_s = 1'b1;
            state_n     = ST_HOLD;
          end
        end else if (branch_enable) begin
          // Address must stay put until the memory answers.
          pend_pc_n = br_addr;
          state_n   = ST_DISCARD;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_DISCARD: begin
        // Youngest redirect wins.
        if (branch_enable) begin
          pend_pc_n = br_addr;
        end else begin
          pend_pc_n = pend_pc_r;
        end
        if (imem.imem_resp) begin
          drop_resp_s = 1'b1;
          state_n     = ST_REQ;
          if (branch_enable) begin
            pc_n = br_addr;
          end else begin
            pc_n = pend_pc_r;
          end
        end else begin
          state_n = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        if (branch_enable) begin
          pc_n    = br_addr;
          state_n = ST_REQ;
        end else if (!stall) begin
          out_load_skid_s = 1'b1;
          state_n         = ST_REQ;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_REQ;
      end
    endcase
  end

  // FSM outputs: memory request, address and pipeline flush.
  always_comb begin
    imem.imem_read    = 1'b0;
    imem.imem_address = pc_r;
    flush             = branch_enable;
    case (state_r)
      ST_REQ:     imem.imem_read = !rst;
      ST_DISCARD: imem.imem_read = !rst;
      ST_HOLD:    imem.imem_read = 1'b0;
      default:    imem.imem_read = 1'b0;
    endcase
  end

  // PC and parked redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      pend_pc_r <= 16'h0000;
    end else begin
      pc_r      <= pc_n;
      pend_pc_r <= pend_pc_n;
    end
  end

  // IF/ID output register: redirect clears, refill beats consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_r    <= 1'b0;
      if_pc_r       <= 16'h0000;
      if_pc_plus2_r <= 16'h0000;
      if_ir_r       <= 16'h0000;
    end else if (branch_enable) begin
      if_valid_r <= 1'b0;
    end else if (out_load_mem_s) begin
      if_valid_r    <= 1'b1;
      if_pc_r       <= pc_r;
      if_pc_plus2_r <= pc_plus2_s;
      if_ir_r       <= imem.imem_rdata;
    end else if (out_load_skid_s) begin
      if_valid_r    <= 1'b1;
      if_pc_r       <= skid_pc_r;
      if_pc_plus2_r <= skid_pc_r + 16'd2;
      if_ir_r       <= skid_ir_r;
    end else if (consume_s) begin
      if_valid_r <= 1'b0;
    end
  end

  // Skid buffer: catches a response while the output register is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 16'h0000;
      skid_ir_r    <= 16'h0000;
    end else if (branch_enable) begin
      skid_valid_r <= 1'b0;
    end else if (skid_load_s) begin
      skid_valid_r <= 1'b1;
      skid_pc_r    <= pc_r;
      skid_ir_r    <= imem.imem_rdata;
    end else if (out_load_skid_s) begin
      skid_valid_r <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_r;
  logic [31:0] perf_squashed_r;
  logic [1:0]  squash_inc_s;
  logic [32:0] redir_sum_s;
  logic [32:0] squash_sum_s;

  assign perf_redirects = perf_redirects_r;
  assign perf_squashed  = perf_squashed_r;

  // Per-cycle squash count: dropped response plus valid entries a redirect kills.
  always_comb begin
    squash_inc_s = {1'b0, drop_resp_s}
                 + {1'b0, branch_enable & if_valid_r}
                 + {1'b0, branch_enable & skid_valid_r};
    redir_sum_s  = {1'b0, perf_redirects_r} + {32'd0, branch_enable};
    squash_sum_s = {1'b0, perf_squashed_r} + {31'd0, squash_inc_s};
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects_r <= 32'd0;
      perf_squashed_r  <= 32'd0;
    end else begin
      perf_redirects_r <= redir_sum_s[32]  ? 32'hFFFF_FFFF : redir_sum_s[31:0];
      perf_squashed_r  <= squash_sum_s[32] ? 32'hFFFF_FFFF : squash_sum_s[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed self-checking bench for if_fetch_redirect.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, i.e. well away from the rising edge.
module tb_if_fetch_redirect;
  logic        clk = 1'b0;
  logic        rst;
  logic        branch_enable;
  logic [15:0] br_addr;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic [15:0] if_ir;
  logic        flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_squashed;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_redirect_if imem_bus ();

  if_fetch_redirect #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_enable (branch_enable),
    .br_addr       (br_addr),
    .stall         (stall),
    .imem          (imem_bus),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pc_plus2   (if_pc_plus2),
    .if_ir         (if_ir),
    .flush         (flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_squashed (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic set_in(input logic r, input logic be, input logic [15:0] ba,
                        input logic st, input logic rs, input logic [15:0] rd);
    rst                = r;
    branch_enable      = be;
    br_addr            = ba;
    stall              = st;
    imem_bus.imem_resp  = rs;
    imem_bus.imem_rdata = rd;
  endtask

  task automatic do_reset;
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stream n single-cycle responses from address 0 upward, no stall.
  task automatic stream(input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = 16'(2 * k);
      set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(a));
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read0: got %b want %b", imem_bus.imem_read, 1'b0); end
    @(negedge clk);
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want %b", if_valid, 1'b0); end
    n_cmp++; if (if_pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc: got %h want %h", if_pc, 16'h0000); end
    n_cmp++; if (if_pc_plus2 !== 16'h0000) begin n_bad++; $display("FAIL reset_pc_plus2: got %h want %h", if_pc_plus2, 16'h0000); end
    n_cmp++; if (if_ir !== 16'h0000) begin n_bad++; $display("FAIL reset_ir: got %h want %h", if_ir, 16'h0000); end
    n_cmp++; if (imem_bus.imem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read1: got %b want %b", imem_bus.imem_read, 1'b0); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b1) begin n_bad++; $display("FAIL reset_first_read: got %b want %b", imem_bus.imem_read, 1'b1); end
    n_cmp++; if (imem_bus.imem_address !== 16'h0000) begin n_bad++; $display("FAIL reset_first_addr: got %h want %h", imem_bus.imem_address, 16'h0000); end
    @(negedge clk);
  endtask

  task automatic test_streaming;
    logic [15:0] a;
    logic [15:0] p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 16'(2 * i);
      set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(a));
      #1;
      n_cmp++; if (imem_bus.imem_address !== a) begin n_bad++; $display("FAIL stream_addr: got %h want %h", imem_bus.imem_address, a); end
      n_cmp++; if (imem_bus.imem_read !== 1'b1) begin n_bad++; $display("FAIL stream_read: got %b want %b", imem_bus.imem_read, 1'b1); end
      if (i > 0) begin
        p = a - 16'd2;
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid: got %b want %b", if_valid, 1'b1); end
        n_cmp++; if (if_pc !== p) begin n_bad++; $display("FAIL stream_pc: got %h want %h", if_pc, p); end
        n_cmp++; if (if_pc_plus2 !== a) begin n_bad++; $display("FAIL stream_pc_plus2: got %h want %h", if_pc_plus2, a); end
        n_cmp++; if (if_ir !== mem_word(p)) begin n_bad++; $display("FAIL stream_ir: got %h want %h", if_ir, mem_word(p)); end
      end
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (if_pc !== 16'h0006) begin n_bad++; $display("FAIL stream_last_pc: got %h want %h", if_pc, 16'h0006); end
    n_cmp++; if (if_ir !== mem_word(16'h0006)) begin n_bad++; $display("FAIL stream_last_ir: got %h want %h", if_ir, mem_word(16'h0006)); end
    @(negedge clk);
  endtask

  task automatic test_discard;
    do_reset();
    stream(3);
    set_in(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL discard_flush_on: got %b want %b", flush, 1'b1); end
    n_cmp++; if (imem_bus.imem_address !== 16'h0006) begin n_bad++; $display("FAIL discard_addr0: got %h want %h", imem_bus.imem_address, 16'h0006); end
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'h0006));
      else        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      #1;
      n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL discard_flush_off: got %b want %b", flush, 1'b0); end
      n_cmp++; if (imem_bus.imem_address !== 16'h0006) begin n_bad++; $display("FAIL discard_addr_hold: got %h want %h", imem_bus.imem_address, 16'h0006); end
      n_cmp++; if (imem_bus.imem_read !== 1'b1) begin n_bad++; $display("FAIL discard_read: got %b want %b", imem_bus.imem_read, 1'b1); end
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL discard_valid: got %b want %b", if_valid, 1'b0); end
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (imem_bus.imem_address !== 16'h3000) begin n_bad++; $display("FAIL discard_target: got %h want %h", imem_bus.imem_address, 16'h3000); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL discard_dropped: got %b want %b", if_valid, 1'b0); end
    @(negedge clk);
  endtask

  task automatic test_coincident;
    do_reset();
    stream(4);
    set_in(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, mem_word(16'h0008));
    #1;
    n_cmp++; if (imem_bus.imem_address !== 16'h0008) begin n_bad++; $display("FAIL coinc_addr: got %h want %h", imem_bus.imem_address, 16'h0008); end
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL coinc_flush: got %b want %b", flush, 1'b1); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'h0100));
    #1;
    n_cmp++; if (imem_bus.imem_address !== 16'h0100) begin n_bad++; $display("FAIL coinc_target: got %h want %h", imem_bus.imem_address, 16'h0100); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL coinc_dropped: got %b want %b", if_valid, 1'b0); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (if_pc !== 16'h0100) begin n_bad++; $display("FAIL coinc_next_pc: got %h want %h", if_pc, 16'h0100); end
    n_cmp++; if (if_ir !== mem_word(16'h0100)) begin n_bad++; $display("FAIL coinc_next_ir: got %h want %h", if_ir, mem_word(16'h0100)); end
    @(negedge clk);
  endtask

  task automatic test_stall_skid;
    do_reset();
    stream(9);
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, mem_word(16'h0012));
    #1;
    n_cmp++; if (imem_bus.imem_address !== 16'h0012) begin n_bad++; $display("FAIL skid_addr: got %h want %h", imem_bus.imem_address, 16'h0012); end
    n_cmp++; if (if_pc !== 16'h0010) begin n_bad++; $display("FAIL skid_pc_pre: got %h want %h", if_pc, 16'h0010); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b0) begin n_bad++; $display("FAIL skid_hold_read: got %b want %b", imem_bus.imem_read, 1'b0); end
    n_cmp++; if (if_pc !== 16'h0010) begin n_bad++; $display("FAIL skid_hold_pc: got %h want %h", if_pc, 16'h0010); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b0) begin n_bad++; $display("FAIL skid_release_read: got %b want %b", imem_bus.imem_read, 1'b0); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL skid_release_valid: got %b want %b", if_valid, 1'b1); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'h0014));
    #1;
    n_cmp++; if (if_pc !== 16'h0012) begin n_bad++; $display("FAIL skid_out_pc: got %h want %h", if_pc, 16'h0012); end
    n_cmp++; if (if_ir !== mem_word(16'h0012)) begin n_bad++; $display("FAIL skid_out_ir: got %h want %h", if_ir, mem_word(16'h0012)); end
    n_cmp++; if (if_pc_plus2 !== 16'h0014) begin n_bad++; $display("FAIL skid_out_pc_plus2: got %h want %h", if_pc_plus2, 16'h0014); end
    n_cmp++; if (imem_bus.imem_address !== 16'h0014) begin n_bad++; $display("FAIL skid_next_addr: got %h want %h", imem_bus.imem_address, 16'h0014); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (if_pc !== 16'h0014) begin n_bad++; $display("FAIL skid_after_pc: got %h want %h", if_pc, 16'h0014); end
    @(negedge clk);
  endtask

  task automatic test_hold_redirect_wrap;
    do_reset();
    stream(1);
    set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, mem_word(16'h0002));
    @(negedge clk);
    set_in(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b0) begin n_bad++; $display("FAIL wrap_hold_read: got %b want %b", imem_bus.imem_read, 1'b0); end
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL wrap_flush: got %b want %b", flush, 1'b1); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'hFFFE));
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_cleared: got %b want %b", if_valid, 1'b0); end
    n_cmp++; if (imem_bus.imem_address !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_addr0: got %h want %h", imem_bus.imem_address, 16'hFFFE); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'h0000));
    #1;
    n_cmp++; if (imem_bus.imem_address !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr1: got %h want %h", imem_bus.imem_address, 16'h0000); end
    n_cmp++; if (if_pc !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_pc: got %h want %h", if_pc, 16'hFFFE); end
    n_cmp++; if (if_pc_plus2 !== 16'h0000) begin n_bad++; $display("FAIL wrap_pc_plus2: got %h want %h", if_pc_plus2, 16'h0000); end
    n_cmp++; if (if_ir !== mem_word(16'hFFFE)) begin n_bad++; $display("FAIL wrap_ir: got %h want %h", if_ir, mem_word(16'hFFFE)); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (if_pc !== 16'h0000) begin n_bad++; $display("FAIL wrap_next_pc: got %h want %h", if_pc, 16'h0000); end
    n_cmp++; if (if_ir !== mem_word(16'h0000)) begin n_bad++; $display("FAIL wrap_next_ir: got %h want %h", if_ir, mem_word(16'h0000)); end
    @(negedge clk);
  endtask

  task automatic test_mid_read_reset;
    do_reset();
    stream(1);
    set_in(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (imem_bus.imem_address !== 16'h0002) begin n_bad++; $display("FAIL rstmid_pending_addr: got %h want %h", imem_bus.imem_address, 16'h0002); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (perf_redirects !== 32'd1) begin n_bad++; $display("FAIL perf_redirects_pre: got %0d want %0d", perf_redirects, 1); end
    n_cmp++; if (perf_squashed !== 32'd1) begin n_bad++; $display("FAIL perf_squashed_pre: got %0d want %0d", perf_squashed, 1); end
`endif
    @(negedge clk);
    set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'h0002));
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b0) begin n_bad++; $display("FAIL rstmid_read: got %b want %b", imem_bus.imem_read, 1'b0); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mem_word(16'h0000));
    #1;
    n_cmp++; if (imem_bus.imem_read !== 1'b1) begin n_bad++; $display("FAIL rstmid_read_after: got %b want %b", imem_bus.imem_read, 1'b1); end
    n_cmp++; if (imem_bus.imem_address !== 16'h0000) begin n_bad++; $display("FAIL rstmid_addr: got %h want %h", imem_bus.imem_address, 16'h0000); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want %b", if_valid, 1'b0); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (perf_redirects !== 32'd0) begin n_bad++; $display("FAIL perf_redirects_rst: got %0d want %0d", perf_redirects, 0); end
    n_cmp++; if (perf_squashed !== 32'd0) begin n_bad++; $display("FAIL perf_squashed_rst: got %0d want %0d", perf_squashed, 0); end
`endif
    @(negedge clk);
    set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #1;
    n_cmp++; if (if_pc !== 16'h0000) begin n_bad++; $display("FAIL rstmid_first_pc: got %h want %h", if_pc, 16'h0000); end
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_first_valid: got %b want %b", if_valid, 1'b1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_discard();
    test_coincident();
    test_stall_skid();
    test_hold_redirect_wrap();
    test_mid_read_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_redirect.md
Name: if_fetch_redirect

Overview:
IF-stage fetch and PC unit for the LC-3b pipeline. It is the consumer of the EX-stage branch-resolution outputs (branch_enable, br_addr). It owns the PC and drives the instruction-memory read handshake. It presents fetched instructions to IF/ID and redirects fetch on a taken branch. A redirect that arrives while a memory read is outstanding is handled by completing and discarding that read, because the memory requires a stable address until it responds.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
branch_enable  in  1  taken-branch redirect from EX
br_addr  in  16  redirect target (lc3b_word)
stall  in  1  IF/ID cannot accept; output register holds
imem_read  out  1  instruction read request
imem_address  out  16  read address, stable while imem_read && !imem_resp
imem_resp  in  1  read complete this cycle
imem_rdata  in  16  instruction word, valid with imem_resp
if_valid  out  1  instruction presented to IF/ID
if_pc  out  16  PC of presented instruction
if_pc_plus2  out  16  if_pc + 2
if_ir  out  16  presented instruction
flush  out  1  squash IF/ID and ID/EX this cycle

Behaviour:
- Clock and reset: single clock clk; synchronous active-high rst.
- Reset values: pc=RESET_PC; state=REQ; if_valid=0; if_pc, if_pc_plus2, if_ir = 0; skid empty; pend_pc=0; imem_read=0 in the reset cycle.
- flush = branch_enable, combinational, in every state.
- Output register (if_*): consumed on a rising edge with if_valid=1 and stall=0. A consumed entry is cleared unless it is refilled in the same cycle.
- Empty-or-consumed condition: the output register can load when if_valid=0 or stall=0.
- Redirect handling: branch_enable always clears if_valid and the skid buffer at the next edge. The redirect takes priority over any response arriving in the same cycle, and that response is dropped.
- State REQ: imem_read=1, imem_address=pc.
  - resp && branch_enable: drop the response; pc<=br_addr; stay in REQ. The next request issues the following cycle.
  - resp && !branch_enable && output register can load: load if_ir=rdata, if_pc=pc, if_pc_plus2=pc+2, if_valid=1; pc<=pc+2.
  - resp && !branch_enable && if_valid && stall: place the response in the skid buffer; pc<=pc+2; go to HOLD.
  - !resp && branch_enable: pend_pc<=br_addr; go to DISCARD.
- State DISCARD: imem_read=1 at the old pc, which is unchanged.
  - A further branch_enable overwrites pend_pc, so the youngest redirect wins.
  - On resp: drop rdata; pc<=pend_pc, or br_addr if branch_enable is high the same cycle; go to REQ.
- State HOLD: imem_read=0.
  - branch_enable: clear skid; pc<=br_addr; go to REQ.
  - Else if stall=0: skid moves to the output register (if_valid=1); go to REQ.
- Reset mid-transaction: the FSM returns to REQ at RESET_PC. The memory must tolerate imem_read dropping for the reset cycle, and any response arriving in the reset cycle is ignored.
- Arithmetic: all PC arithmetic is 16-bit modulo. 16'hFFFE+2 wraps to 16'h0000.
- Ordering: at most one read is outstanding. Instructions are delivered in fetch order, with no duplicates and no losses.

Optional Feature:
FETCH_PERF_CNT_EN
- When defined, adds output ports perf_redirects[31:0] and perf_squashed[31:0].
- perf_redirects counts cycles with branch_enable=1.
- perf_squashed counts dropped imem responses plus valid if_valid/skid entries cleared by a redirect.
- Both counters saturate at 32'hFFFFFFFF and are cleared by rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Streaming fetch, from reset with stall=0 and 1-cycle resp: addresses 0000, 0002, 0004, ... Each response appears on if_* the next cycle with if_pc_plus2=if_pc+2.
2. Redirect during DISCARD: branch_enable with br_addr=16'h3000 while a read at 0006 is pending (resp 3 cycles later). imem_address holds 0006 until resp. The 0006 data is never presented. The next request is to 3000, and flush=1 only in the branch_enable cycle.
3. Redirect coincident with response: resp for 0008 with branch_enable and br_addr=16'h0100 in the same cycle. 0008 is dropped, and the next imem_address is 0100.
4. Stall and skid: stall=1 with if_valid=1 (pc 0010) when resp for 0012 arrives. The FSM enters HOLD with imem_read=0. When stall drops, 0010 is consumed, then 0012 is presented. Next fetch is 0014.
5. Redirect in HOLD and wrap: in HOLD, branch_enable with br_addr=16'hFFFE. Skid and if_valid are cleared, and the fetch sequence is FFFE then 0000.
6. Mid-read reset: rst while a read is pending. imem_read=0 in the reset cycle, and the next request is to RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0 after reset.
